axi4_lite_slave_read_pipe: RTL and testbench



---
 rtl/axi4_lite_pkg.sv | 16 +
 rtl/axi4_lite_resp_fifo.sv | 63 ++++++
 rtl/axi4_lite_slave_read_pipe.sv | 139 +++++++++++++
 tb/tb_axi4_lite_slave_read_pipe.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi4_lite_pkg.sv
// Shared AXI4-Lite response encodings for the read and write slaves.
// Ports: none (package).
// Contents: resp_t, RESP_OKAY/RESP_SLVERR, backend result mapping helper.
package axi4_lite_pkg;

  typedef logic [1:0] resp_t;

  localparam resp_t RESP_OKAY   = 2'b00;
  localparam resp_t RESP_SLVERR = 2'b10;

  // Backend reports 1 for success; anything else is a slave error.
  function automatic resp_t backend_resp(input logic ok);
    return ok ? RESP_OKAY : RESP_SLVERR;
  endfunction

endpackage

// File: rtl/axi4_lite_resp_fifo.sv
// In-order response FIFO holding {resp, data}; head is driven straight from storage registers.
// Ports: clk/rst_n; push_i + push_resp_i/push_data_i; pop_i; empty_o/full_o; head_resp_o/head_data_o.
// Push and pop may coincide at any occupancy; pointers wrap modulo depth.
module axi4_lite_resp_fifo
  import axi4_lite_pkg::*;
#(
  parameter int data_width = 32,
  parameter int depth      = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push_i,
  input  resp_t                 push_resp_i,
  input  logic [data_width-1:0] push_data_i,
  input  logic                  pop_i,
  output logic                  empty_o,
  output logic                  full_o,
  output resp_t                 head_resp_o,
  output logic [data_width-1:0] head_data_o
);

  localparam int PW = (depth > 1) ? $clog2(depth) : 1;
  localparam int CW = $clog2(depth + 1);
  localparam int EW = data_width + 2;

  logic [EW-1:0] mem_q [depth];
  logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(depth - 1)) return '0;
    return p + PW'(1);
  endfunction

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q + CW'(push_i) - CW'(pop_i);
    if (push_i) wptr_d = ptr_inc(wptr_q);
    if (pop_i)  rptr_d = ptr_inc(rptr_q);
  end

  // Storage is reset too, so the head reads as zero straight out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < depth; i++) mem_q[i] <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_i) mem_q[wptr_q] <= {push_resp_i, push_data_i};
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  assign empty_o     = (count_q == '0);
  assign full_o      = (count_q == CW'(depth));
  assign head_resp_o = mem_q[rptr_q][EW-1 -: 2];
  assign head_data_o = mem_q[rptr_q][data_width-1:0];

endmodule

// File: rtl/axi4_lite_slave_read_pipe.sv
// AXI4-Lite read slave: up to resp_depth outstanding ARs, issued in order to a register backend.
// Ports: clk/rst_n; backend read_req/read_addr/read_prot out, read_ready/read_response/read_value in;
//        AXI AR (araddr/arprot/arvalid/arready) and R (rdata/rresp/rvalid/rready) channels.
module axi4_lite_slave_read_pipe
  import axi4_lite_pkg::*;
#(
  parameter int addr_width     = 7,
  parameter int data_width     = 32,
  parameter int resp_depth     = 2,
  parameter int timeout_cycles = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  read_req,
  output logic [addr_width-1:0] read_addr,
  output logic [2:0]            read_prot,
  input  logic                  read_ready,
  input  logic                  read_response,
  input  logic [data_width-1:0] read_value,
  input  logic [addr_width-1:0] s_axi_araddr,
  input  logic [2:0]            s_axi_arprot,
  input  logic                  s_axi_arvalid,
  output logic                  s_axi_arready,
  output logic [data_width-1:0] s_axi_rdata,
  output logic [1:0]            s_axi_rresp,
  output logic                  s_axi_rvalid,
  input  logic                  s_axi_rready
);

  if (!(data_width == 32 || data_width == 64)) begin : g_bad_data_width
    $error("axi4_lite_slave_read_pipe: data_width must be 32 or 64");
  end
  if (resp_depth < 1) begin : g_bad_resp_depth
    $error("axi4_lite_slave_read_pipe: resp_depth must be at least 1");
  end

  localparam int OW = $clog2(resp_depth + 1);

  logic                  arready_q, arready_d;
  logic                  req_q, req_d;
  logic [addr_width-1:0] addr_q, addr_d;
  logic [2:0]            prot_q, prot_d;
  logic [OW-1:0]         outst_q, outst_d;

  logic                  ar_hs, r_hs, complete, timeout_hit;
  logic                  fifo_empty, fifo_full, fifo_push, fifo_pop;
  resp_t                 push_resp, head_resp;
  logic [data_width-1:0] push_data;

  assign ar_hs    = s_axi_arvalid & arready_q;
  assign r_hs     = s_axi_rvalid & s_axi_rready;
  assign complete = req_q & (read_ready | timeout_hit);

  // Timeout counter exists only when enabled; it counts request cycles without read_ready.
  if (timeout_cycles > 0) begin : g_tmo
    localparam int TW = (timeout_cycles > 1) ? $clog2(timeout_cycles) : 1;
    logic [TW-1:0] tcnt_q, tcnt_d;

    always_comb begin
      tcnt_d = tcnt_q;
      if (ar_hs)                    tcnt_d = '0;
      else if (req_q && !read_ready) tcnt_d = tcnt_q + TW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) tcnt_q <= '0;
      else        tcnt_q <= tcnt_d;
    end

    // A real read_ready in the last allowed cycle takes priority over the timeout.
    assign timeout_hit = req_q & ~read_ready & (tcnt_q == TW'(timeout_cycles - 1));
  end else begin : g_no_tmo
    assign timeout_hit = 1'b0;
  end

  always_comb begin
    outst_d = outst_q + OW'(ar_hs) - OW'(r_hs);
    req_d   = req_q;
    addr_d  = addr_q;
    prot_d  = prot_q;
    // ar_hs only happens while the slot is idle, so it never collides with a completion.
    if (ar_hs) begin
      req_d  = 1'b1;
      addr_d = s_axi_araddr;
      prot_d = s_axi_arprot;
    end else if (complete) begin
      req_d  = 1'b0;
    end
    // Accept again only if there is room for another response and the backend slot frees up.
    arready_d = (outst_d < OW'(resp_depth)) & ~ar_hs & (~req_q | complete);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      arready_q <= 1'b0;
      req_q     <= 1'b0;
      addr_q    <= '0;
      prot_q    <= '0;
      outst_q   <= '0;
    end else begin
      arready_q <= arready_d;
      req_q     <= req_d;
      addr_q    <= addr_d;
      prot_q    <= prot_d;
      outst_q   <= outst_d;
    end
  end

  // Timeout completions carry SLVERR with zero data.
  assign push_resp = read_ready ? backend_resp(read_response) : RESP_SLVERR;
  assign push_data = read_ready ? read_value : '0;
  // The outstanding limit already keeps the FIFO from filling; the full term is a cheap backstop.
  assign fifo_push = complete & (~fifo_full | fifo_pop);
  assign fifo_pop  = r_hs;

  axi4_lite_resp_fifo #(
    .data_width (data_width),
    .depth      (resp_depth)
  ) u_resp_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (fifo_push),
    .push_resp_i (push_resp),
    .push_data_i (push_data),
    .pop_i       (fifo_pop),
    .empty_o     (fifo_empty),
    .full_o      (fifo_full),
    .head_resp_o (head_resp),
    .head_data_o (s_axi_rdata)
  );

  assign s_axi_rvalid  = ~fifo_empty;
  assign s_axi_rresp   = head_resp;
  assign s_axi_arready = arready_q;
  assign read_req      = req_q;
  assign read_addr     = addr_q;
  assign read_prot     = prot_q;

endmodule

// File: tb/tb_axi4_lite_slave_read_pipe.sv
// Self-checking bench for axi4_lite_slave_read_pipe (64-bit data, depth 2, timeout 4).
// Directed steps for latency, backpressure, timeout and reset, then a randomized run vs a queue model.
module tb_axi4_lite_slave_read_pipe;

  localparam int AW = 7;
  localparam int DW = 64;
  localparam int RD = 2;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          read_req;
  logic [AW-1:0] read_addr;
  logic [2:0]    read_prot;
  logic          read_ready = 1'b0;
  logic          read_response = 1'b0;
  logic [DW-1:0] read_value = '0;
  logic [AW-1:0] araddr = '0;
  logic [2:0]    arprot = '0;
  logic          arvalid = 1'b0;
  logic          arready;
  logic [DW-1:0] rdata;
  logic [1:0]    rresp;
  logic          rvalid;
  logic          rready = 1'b0;

  axi4_lite_slave_read_pipe #(
    .addr_width     (AW),
    .data_width     (DW),
    .resp_depth     (RD),
    .timeout_cycles (TO)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .read_req      (read_req),
    .read_addr     (read_addr),
    .read_prot     (read_prot),
    .read_ready    (read_ready),
    .read_response (read_response),
    .read_value    (read_value),
    .s_axi_araddr  (araddr),
    .s_axi_arprot  (arprot),
    .s_axi_arvalid (arvalid),
    .s_axi_arready (arready),
    .s_axi_rdata   (rdata),
    .s_axi_rresp   (rresp),
    .s_axi_rvalid  (rvalid),
    .s_axi_rready  (rready)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  bit bk_auto = 1'b0;

  typedef struct {
    logic [AW-1:0] addr;
    logic [2:0]    prot;
    logic [DW-1:0] val;
    logic          ok;
    int            lat;
  } req_s;

  req_s          rq[$];
  logic [65:0]   exq[$];
  logic [DW-1:0] got[$];
  logic [AW-1:0] t2_addr [3];

  task automatic check(input string tag, input logic [65:0] obs, input logic [65:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] bk_val(input logic [AW-1:0] a);
    logic [DW-1:0] base;
    base = 64'hA5A5_0000_0000_0000;
    return base | DW'(a);
  endfunction

  // One clock: optional single-cycle backend, then sample #1 after the rising edge.
  task automatic cyc();
    if (bk_auto) begin
      read_ready    = read_req;
      read_response = 1'b1;
      read_value    = bk_val(read_addr);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int   accepted, received, age, outst;
    logic stall_prev;
    logic [65:0] held;

    // ---------------- reset state ----------------
    repeat (2) @(posedge clk);
    #1;
    check("rst_arready", arready, 0);
    check("rst_rvalid", rvalid, 0);
    check("rst_rdata", rdata, 0);
    check("rst_rresp", rresp, 0);
    check("rst_read_req", read_req, 0);
    check("rst_read_addr", read_addr, 0);
    check("rst_read_prot", read_prot, 0);
    rst_n = 1'b1;
    cyc();
    check("rel_arready", arready, 1);

    // ---------------- single read, 3-cycle latency ----------------
    rready = 1'b1;
    araddr = 7'h10; arprot = 3'd5; arvalid = 1'b1;
    cyc();
    arvalid = 1'b0;
    check("t1_req", read_req, 1);
    check("t1_addr", read_addr, 7'h10);
    check("t1_prot", read_prot, 3'd5);
    check("t1_arready_busy", arready, 0);
    cyc();
    check("t1_req2", read_req, 1);
    check("t1_no_rvalid", rvalid, 0);
    read_ready = 1'b1; read_response = 1'b1; read_value = 64'hDEADBEEF;
    cyc();
    read_ready = 1'b0;
    check("t1_rvalid", rvalid, 1);
    check("t1_rdata", rdata, 64'hDEADBEEF);
    check("t1_rresp", rresp, 2'b00);
    check("t1_arready_back", arready, 1);
    check("t1_req_low", read_req, 0);
    cyc();
    check("t1_rvalid_pop", rvalid, 0);

    // ---------------- depth limit with R backpressure ----------------
    t2_addr[0] = 7'h04; t2_addr[1] = 7'h08; t2_addr[2] = 7'h0C;
    rready = 1'b0; bk_auto = 1'b1;
    araddr = t2_addr[0]; arvalid = 1'b1;
    cyc();
    araddr = t2_addr[1];
    check("t2_req0", read_req, 1);
    cyc();
    check("t2_arready_second", arready, 1);
    check("t2_rvalid_first", rvalid, 1);
    cyc();
    araddr = t2_addr[2];
    check("t2_addr1", read_addr, t2_addr[1]);
    cyc();
    for (int k = 0; k < 3; k++) begin
      check("t2_arready_full", arready, 0);
      check("t2_hold_rvalid", rvalid, 1);
      check("t2_hold_rdata", rdata, bk_val(t2_addr[0]));
      cyc();
    end
    rready = 1'b1;
    for (int i = 0; i < 30 && got.size() < 3; i++) begin
      bit hs;
      hs = arvalid && arready;
      if (rvalid && rready) got.push_back(rdata);
      cyc();
      if (hs) arvalid = 1'b0;
    end
    check("t2_count", got.size(), 3);
    for (int k = 0; k < 3; k++)
      check("t2_order", got.size() > k ? got[k] : 'x, bk_val(t2_addr[k]));
    bk_auto = 1'b0; read_ready = 1'b0;

    // ---------------- timeout, late read_ready ignored ----------------
    araddr = 7'h20; arvalid = 1'b1;
    cyc();
    arvalid = 1'b0;
    for (int k = 0; k < TO; k++) begin
      check("t3_req_high", read_req, 1);
      cyc();
    end
    check("t3_req_dropped", read_req, 0);
    check("t3_rvalid", rvalid, 1);
    check("t3_rresp", rresp, 2'b10);
    check("t3_rdata", rdata, 0);
    cyc();
    check("t3_popped", rvalid, 0);
    cyc();
    read_ready = 1'b1; read_response = 1'b1; read_value = 64'h1111_2222_3333_4444;
    cyc();
    read_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check("t3_late_no_rvalid", rvalid, 0);
      check("t3_late_no_req", read_req, 0);
      cyc();
    end

    // ---------------- read_ready in the last allowed cycle wins ----------------
    araddr = 7'h24; arvalid = 1'b1;
    cyc();
    arvalid = 1'b0;
    repeat (TO - 1) cyc();
    check("t4_req_4th", read_req, 1);
    read_ready = 1'b1; read_response = 1'b0; read_value = 64'hFACE_0000_CAFE_0004;
    cyc();
    read_ready = 1'b0;
    check("t4_rvalid", rvalid, 1);
    check("t4_rresp", rresp, 2'b10);
    check("t4_rdata", rdata, 64'hFACE_0000_CAFE_0004);
    check("t4_req_low", read_req, 0);
    cyc();
    check("t4_no_dup_a", rvalid, 0);
    cyc();
    check("t4_no_dup_b", rvalid, 0);

    // ---------------- randomized: continuous ARs, rready toggling ----------------
    accepted = 0; received = 0; age = 0; outst = 0; stall_prev = 1'b0; held = '0;
    rready = 1'b0;
    arvalid = 1'b1; araddr = AW'($urandom); arprot = 3'($urandom);
    for (int cy = 0; cy < 3000 && received < 50; cy++) begin
      bit   done, ar_hs, req_was;
      rready  = ~rready;
      done    = 1'b0;
      req_was = read_req;
      if (read_req) begin
        check("t5_req_addr", {read_prot, read_addr},
              rq.size() != 0 ? {rq[0].prot, rq[0].addr} : 'x);
        if (rq.size() != 0 && age == rq[0].lat) begin
          read_ready = 1'b1; read_response = rq[0].ok; read_value = rq[0].val;
          done = 1'b1;
        end else begin
          read_ready = 1'b0; read_value = {$urandom, $urandom};
          if (age == TO - 1) done = 1'b1;
        end
      end else begin
        read_ready    = ($urandom_range(0, 7) == 0);
        read_response = 1'($urandom);
        read_value    = {$urandom, $urandom};
      end
      if (stall_prev) begin
        check("t5_rvalid_held", rvalid, 1);
        check("t5_stable", {rresp, rdata}, held);
      end
      if (rvalid) begin
        check("t5_rvalid_owed", exq.size() != 0, 1);
        if (rready) begin
          check("t5_resp", {rresp, rdata}, exq.size() != 0 ? exq[0] : 'x);
          if (exq.size() != 0) void'(exq.pop_front());
          received++;
          outst--;
        end
        stall_prev = !rready;
        held = {rresp, rdata};
      end else begin
        stall_prev = 1'b0;
      end
      if (outst >= RD) check("t5_ar_limit", arready, 0);
      ar_hs = arvalid && arready;
      if (ar_hs) begin
        req_s r;
        r.addr = araddr; r.prot = arprot;
        r.val  = {$urandom, $urandom};
        r.ok   = 1'($urandom);
        r.lat  = int'($urandom_range(0, 5));
        rq.push_back(r);
        exq.push_back(r.lat < TO ? {(r.ok ? 2'b00 : 2'b10), r.val} : {2'b10, 64'd0});
        accepted++;
        outst++;
      end
      cyc();
      if (done) begin
        if (rq.size() != 0) void'(rq.pop_front());
        age = 0;
      end else if (req_was) begin
        age++;
      end
      if (ar_hs) begin
        if (accepted == 50) arvalid = 1'b0;
        else begin araddr = AW'($urandom); arprot = 3'($urandom); end
      end
    end
    check("t5_received", received, 50);
    check("t5_exp_empty", exq.size(), 0);
    check("t5_req_empty", rq.size(), 0);
    read_ready = 1'b0;

    // ---------------- reset with two outstanding and a live request ----------------
    rready = 1'b0;
    araddr = 7'h30; arvalid = 1'b1;
    cyc();
    araddr = 7'h34;
    read_ready = 1'b1; read_response = 1'b1; read_value = bk_val(7'h30);
    cyc();
    read_ready = 1'b0;
    cyc();
    arvalid = 1'b0;
    check("t6_req_live", read_req, 1);
    check("t6_rvalid_live", rvalid, 1);
    check("t6_arready_full", arready, 0);
    rst_n = 1'b0;
    #1;
    check("t6_rst_arready", arready, 0);
    check("t6_rst_rvalid", rvalid, 0);
    check("t6_rst_req", read_req, 0);
    check("t6_rst_rdata", rdata, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc();
    check("t6_rel_arready", arready, 1);
    rready = 1'b1; bk_auto = 1'b1;
    araddr = 7'h3C; arvalid = 1'b1;
    cyc();
    arvalid = 1'b0;
    cyc();
    check("t6_rvalid", rvalid, 1);
    check("t6_rdata", rdata, bk_val(7'h3C));
    check("t6_rresp", rresp, 2'b00);
    cyc();
    check("t6_done", rvalid, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
